// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract unit with NZCV flags, one full adder reused LSB first

module one_bit_full_adder (
    input  logic c_in,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_sr, b_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum, fa_cout;
    logic               last_bit;
    logic [WIDTH-1:0]   result_next;

    one_bit_full_adder u_fa (
        .c_in  (carry),
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
    assign result_next = {fa_sum, result[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B at load and seed the carry with sub.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            n      <= 1'b0;
            z      <= 1'b0;
            c      <= 1'b0;
            v      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    result <= result_next;
                    // On the MSB, carry holds the carry-in and fa_cout the carry-out.
                    if (last_bit) begin
                        n <= fa_sum;
                        z <= ~|result_next;
                        c <= fa_cout;
                        v <= carry ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
